// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and helpers for the ID/EX hazard scoreboard.
// The FWD_* and STAGE_* values are the forward-select and stage-index encodings used by consumers of this block.
package hazard_scoreboard_pkg;

    localparam int FWD_REGFILE    = 0;
    localparam int FWD_STAGE_BASE = 1;

    localparam int STAGE_EX  = 0;
    localparam int STAGE_MEM = 1;
    localparam int STAGE_WB  = 2;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_src_match.sv
// Matches one source register against the in-flight producers in the scoreboard.
// Returns either a forward select or a hazard flag.
module hazard_src_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int REG_ADDR_W = 5,
    parameter int RDY_W      = 2,
    parameter int FWD_W      = 2
)(
    input  logic [NUM_STAGES-1:0]                 i_valid,
    input  logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] i_dest,
    input  logic [NUM_STAGES-1:0][RDY_W-1:0]      i_rdy,
    input  logic                                  i_use,
    input  logic [REG_ADDR_W-1:0]                 i_src,
    output logic                                  o_hazard,
    output logic [FWD_W-1:0]                      o_fwd
);

    logic [NUM_STAGES-1:0] w_hit;

    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_hit[i] = i_valid[i] && i_use && (i_src != '0) && (i_dest[i] == i_src);
        end
    end

    // Walk from oldest to youngest so the youngest hit is the last one written.
    always_comb begin
        o_hazard = 1'b0;
        o_fwd    = FWD_W'(FWD_REGFILE);
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                if (i >= int'(i_rdy[i])) begin
                    o_hazard = 1'b0;
                    o_fwd    = FWD_W'(i + FWD_STAGE_BASE);
                end else begin
                    o_hazard = 1'b1;
                    o_fwd    = FWD_W'(FWD_REGFILE);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall and forwarding unit between ID and EX: shift scoreboard of in-flight producers,
// MDU occupancy counter and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int REG_ADDR_W  = 5,
    parameter int LOAD_READY  = 1,
    parameter int ALU_READY   = 0,
    parameter int MDU_LATENCY = 4,
    parameter int FWD_W       = 2
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_we,
    input  logic                  id_is_load,
    input  logic                  id_is_mdu,
    input  logic                  id_reads_hilo,
    input  logic                  flush,
    output logic                  stall,
    output logic [FWD_W-1:0]      fwd_rs,
    output logic [FWD_W-1:0]      fwd_rt,
    output logic                  mdu_busy,
    output logic [31:0]           stall_cycles
);

    localparam int RDY_W = clog2_min1(NUM_STAGES + 1);
    localparam int CNT_W = clog2_min1(MDU_LATENCY);

    logic [NUM_STAGES-1:0]                 r_valid;
    logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] r_dest;
    logic [NUM_STAGES-1:0][RDY_W-1:0]      r_rdy;
    logic [CNT_W-1:0]                      r_cnt;
    logic [31:0]                           r_stall_cycles;

    logic             w_rs_hazard;
    logic             w_rt_hazard;
    logic [FWD_W-1:0] w_rs_fwd;
    logic [FWD_W-1:0] w_rt_fwd;
    logic             w_mdu_busy;
    logic             w_stall;
    logic             w_issue;

    hazard_src_match #(
        .NUM_STAGES (NUM_STAGES),
        .REG_ADDR_W (REG_ADDR_W),
        .RDY_W      (RDY_W),
        .FWD_W      (FWD_W)
    ) u_rs_match (
        .i_valid  (r_valid),
        .i_dest   (r_dest),
        .i_rdy    (r_rdy),
        .i_use    (id_use_rs),
        .i_src    (id_rs),
        .o_hazard (w_rs_hazard),
        .o_fwd    (w_rs_fwd)
    );

    hazard_src_match #(
        .NUM_STAGES (NUM_STAGES),
        .REG_ADDR_W (REG_ADDR_W),
        .RDY_W      (RDY_W),
        .FWD_W      (FWD_W)
    ) u_rt_match (
        .i_valid  (r_valid),
        .i_dest   (r_dest),
        .i_rdy    (r_rdy),
        .i_use    (id_use_rt),
        .i_src    (id_rt),
        .o_hazard (w_rt_hazard),
        .o_fwd    (w_rt_fwd)
    );

    assign w_mdu_busy = (r_cnt != '0);
    assign w_stall    = id_valid && !flush &&
                        (w_rs_hazard || w_rt_hazard ||
                         (w_mdu_busy && (id_is_mdu || id_reads_hilo)));
    assign w_issue    = id_valid && !w_stall && !flush;

    // A flush squashes whatever sits in EX as it moves on to MEM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dest  <= '0;
            r_rdy   <= '0;
        end else begin
            for (int i = NUM_STAGES - 1; i > 0; i--) begin
                r_valid[i] <= r_valid[i-1] && !(flush && (i == STAGE_MEM));
                r_dest[i]  <= r_dest[i-1];
                r_rdy[i]   <= r_rdy[i-1];
            end
            r_valid[STAGE_EX] <= w_issue && id_we && (id_dest != '0);
            r_dest[STAGE_EX]  <= id_dest;
            r_rdy[STAGE_EX]   <= id_is_load ? RDY_W'(LOAD_READY) : RDY_W'(ALU_READY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_issue && id_is_mdu) begin
            r_cnt <= CNT_W'(MDU_LATENCY - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall) begin
            r_stall_cycles <= sat_inc32(r_stall_cycles);
        end
    end

    assign stall        = w_stall;
    assign fwd_rs       = w_rs_fwd;
    assign fwd_rt       = w_rt_fwd;
    assign mdu_busy     = w_mdu_busy;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: the driver pushes expected outputs from a
// cycle-history reference model, and a negedge monitor pops and compares them.
module tb_hazard_scoreboard;

    localparam int NUM_STAGES  = 3;
    localparam int REG_ADDR_W  = 5;
    localparam int LOAD_READY  = 1;
    localparam int ALU_READY   = 0;
    localparam int MDU_LATENCY = 4;
    localparam int FWD_W       = 2;

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       useRs;
        logic       useRt;
        logic [4:0] dest;
        logic       we;
        logic       isLoad;
        logic       isMdu;
        logic       readsHilo;
        logic       flush;
        logic       rst;
    } stim_t;

    typedef struct {
        int          cyc;
        logic        stall;
        logic [1:0]  fwdRs;
        logic [1:0]  fwdRt;
        logic        mduBusy;
        logic [31:0] stallCycles;
    } exp_t;

    typedef struct {
        bit         valid;
        logic [4:0] dest;
        bit         isLoad;
    } prod_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        idValid;
    logic [4:0]  idRs;
    logic [4:0]  idRt;
    logic        idUseRs;
    logic        idUseRt;
    logic [4:0]  idDest;
    logic        idWe;
    logic        idIsLoad;
    logic        idIsMdu;
    logic        idReadsHilo;
    logic        flush;
    logic        stall;
    logic [1:0]  fwdRs;
    logic [1:0]  fwdRt;
    logic        mduBusy;
    logic [31:0] stallCycles;

    int    checks   = 0;
    int    failures = 0;
    int    cycle    = 0;
    exp_t  expQ[$];
    prod_t hist[$];
    stim_t cur;
    bit    curStall;
    bit    mduStarted;
    int    mduCycle;
    int    modelStallCount;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_STAGES  (NUM_STAGES),
        .REG_ADDR_W  (REG_ADDR_W),
        .LOAD_READY  (LOAD_READY),
        .ALU_READY   (ALU_READY),
        .MDU_LATENCY (MDU_LATENCY),
        .FWD_W       (FWD_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (idValid),
        .id_rs         (idRs),
        .id_rt         (idRt),
        .id_use_rs     (idUseRs),
        .id_use_rt     (idUseRt),
        .id_dest       (idDest),
        .id_we         (idWe),
        .id_is_load    (idIsLoad),
        .id_is_mdu     (idIsMdu),
        .id_reads_hilo (idReadsHilo),
        .flush         (flush),
        .stall         (stall),
        .fwd_rs        (fwdRs),
        .fwd_rt        (fwdRt),
        .mdu_busy      (mduBusy),
        .stall_cycles  (stallCycles)
    );

    function automatic stim_t mkInstr(logic [4:0] rs, logic useRs, logic [4:0] rt, logic useRt,
                                      logic [4:0] dest, logic we, logic isLoad,
                                      logic isMdu, logic readsHilo);
        stim_t s;
        s.valid = 1'b1;  s.rs = rs;  s.rt = rt;  s.useRs = useRs;  s.useRt = useRt;
        s.dest = dest;   s.we = we;  s.isLoad = isLoad;  s.isMdu = isMdu;
        s.readsHilo = readsHilo;  s.flush = 1'b0;  s.rst = 1'b0;
        return s;
    endfunction

    function automatic stim_t mkIdle(logic fl, logic rs);
        stim_t s;
        s = mkInstr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        s.valid = 1'b0;
        s.flush = fl;
        s.rst = rs;
        return s;
    endfunction

    // Model: hist[k] is the producer that entered EX k edges ago (k=0 is the youngest).
    task automatic modelEdge();
        prod_t p;
        bit issue;
        cycle++;
        if (cur.rst) begin
            hist.delete();
            mduStarted = 0;
            modelStallCount = 0;
            return;
        end
        issue = cur.valid && !curStall && !cur.flush;
        if (cur.flush && hist.size() > 0) hist[0].valid = 0;
        p.valid  = issue && cur.we && (cur.dest != 5'd0);
        p.dest   = cur.dest;
        p.isLoad = cur.isLoad;
        hist.push_front(p);
        while (hist.size() > NUM_STAGES) void'(hist.pop_back());
        if (issue && cur.isMdu) begin
            mduStarted = 1;
            mduCycle = cycle;
        end
        if (curStall && modelStallCount != 32'hFFFF_FFFF) modelStallCount++;
    endtask

    task automatic lookup(input logic use_, input logic [4:0] src, output int fwd, output bit haz);
        fwd = 0;
        haz = 0;
        if (!use_ || src == 5'd0) return;
        for (int k = 0; k < hist.size(); k++) begin
            if (hist[k].valid && hist[k].dest == src) begin
                if (k >= (hist[k].isLoad ? LOAD_READY : ALU_READY)) fwd = k + 1;
                else haz = 1;
                return;
            end
        end
    endtask

    task automatic stepCycle(input stim_t s, output bit expStall);
        exp_t e;
        int fr, ft;
        bit hr, ht, busy;
        @(posedge clk);
        modelEdge();
        #1;
        cur = s;
        rst = s.rst;  idValid = s.valid;  idRs = s.rs;  idRt = s.rt;
        idUseRs = s.useRs;  idUseRt = s.useRt;  idDest = s.dest;  idWe = s.we;
        idIsLoad = s.isLoad;  idIsMdu = s.isMdu;  idReadsHilo = s.readsHilo;  flush = s.flush;
        lookup(s.useRs, s.rs, fr, hr);
        lookup(s.useRt, s.rt, ft, ht);
        busy = mduStarted && ((cycle - mduCycle) < MDU_LATENCY - 1);
        e.cyc         = cycle;
        e.stall       = s.valid && !s.flush && (hr || ht || (busy && (s.isMdu || s.readsHilo)));
        e.fwdRs       = 2'(fr);
        e.fwdRt       = 2'(ft);
        e.mduBusy     = busy;
        e.stallCycles = modelStallCount;
        expQ.push_back(e);
        curStall = e.stall;
        expStall = e.stall;
    endtask

    // Holds an instruction in ID until the model lets it issue, as the real front end would.
    task automatic applyStimulus(input stim_t s);
        bit st;
        int n = 0;
        do begin
            stepCycle(s, st);
            n++;
        end while (st && n < 20);
        if (st) begin
            checks++;
            failures++;
            $display("[TB] FAIL issue_timeout cyc=%0d still stalled after %0d cycles", cycle, n);
        end
    endtask

    task automatic checkField(input string name, input int cyc, input logic [31:0] got,
                              input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("stall",        e.cyc, 32'(stall),   32'(e.stall));
        checkField("fwd_rs",       e.cyc, 32'(fwdRs),   32'(e.fwdRs));
        checkField("fwd_rt",       e.cyc, 32'(fwdRt),   32'(e.fwdRt));
        checkField("mdu_busy",     e.cyc, 32'(mduBusy), 32'(e.mduBusy));
        checkField("stall_cycles", e.cyc, stallCycles,  e.stallCycles);
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    initial begin
        stim_t s;
        bit st;
        cur = mkIdle(1'b0, 1'b1);
        curStall = 0;
        mduStarted = 0;
        modelStallCount = 0;
        rst = 1'b1;  idValid = 1'b0;  idRs = '0;  idRt = '0;  idUseRs = 1'b0;  idUseRt = 1'b0;
        idDest = '0;  idWe = 1'b0;  idIsLoad = 1'b0;  idIsMdu = 1'b0;  idReadsHilo = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);

        stepCycle(mkIdle(1'b0, 1'b0), st);
        for (int i = 0; i < 5; i++)
            applyStimulus(mkInstr(5'(20 + i), 1'b1, 5'(25 + i), 1'b1, 5'(11 + i), 1'b1, 1'b0, 1'b0, 1'b0));

        applyStimulus(mkInstr(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        applyStimulus(mkInstr(5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0));
        applyStimulus(mkInstr(5'd0, 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0));

        applyStimulus(mkInstr(5'd9, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0));
        applyStimulus(mkInstr(5'd8, 1'b1, 5'd8, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0));

        applyStimulus(mkInstr(5'd1, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0));
        applyStimulus(mkInstr(5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0));
        applyStimulus(mkInstr(5'd1, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0));
        applyStimulus(mkInstr(5'd6, 1'b1, 5'd6, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0));

        applyStimulus(mkInstr(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        applyStimulus(mkInstr(5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b1));

        applyStimulus(mkInstr(5'd9, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0));
        stepCycle(mkIdle(1'b1, 1'b0), st);
        applyStimulus(mkInstr(5'd8, 1'b1, 5'd8, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0));

        applyStimulus(mkInstr(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        s = mkInstr(5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b1);
        stepCycle(s, st);
        s.rst = 1'b1;
        stepCycle(s, st);
        s.rst = 1'b0;
        stepCycle(s, st);

        // Random traffic over a small register set so hazards and forwards are frequent.
        for (int n = 0; n < 600; n++) begin
            if (!curStall || cur.rst) begin
                s = mkInstr(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                            5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                            1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) == 0),
                            1'($urandom_range(0, 9) == 0));
                s.valid = ($urandom_range(0, 9) < 8);
            end else begin
                s = cur;
            end
            s.flush = ($urandom_range(0, 19) == 0);
            s.rst   = ($urandom_range(0, 99) == 0);
            stepCycle(s, st);
        end

        stepCycle(mkIdle(1'b0, 1'b0), st);
        repeat (2) @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain pending=%0d expected=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
